arp_responder: RTL and testbench

ARP protocol engine sitting directly upstream of the ARP Ethernet transmitter. It consumes parsed ARP frames from the ARP receive path and answers requests that target the local IP address. It also issues locally commanded ARP requests. Every outgoing frame is presented as a parallel-field ARP frame on a valid/ready interface that drives the transmitter's frame input directly.

---
 rtl/arp_pkg.sv | 66 ++++++
 rtl/arp_req_match.sv | 32 +++
 rtl/arp_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_arp_responder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, frame payload struct and frame builder for the ARP responder.
// The gratuitous-ARP feature is selected by ARP_RESPONDER_GRATUITOUS_EN in arp_responder.
package arp_pkg;

    localparam int unsigned MAC_W = 48;
    localparam int unsigned IP_W  = 32;
    localparam int unsigned FLD_W = 16;
    localparam int unsigned LEN_W = 8;

    localparam logic [FLD_W-1:0] ETH_TYPE_ARP     = 16'h0806;
    localparam logic [FLD_W-1:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [FLD_W-1:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [FLD_W-1:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [FLD_W-1:0] ARP_OPER_REPLY   = 16'h0002;
    localparam logic [LEN_W-1:0] ARP_HLEN_ETH     = 8'd6;
    localparam logic [LEN_W-1:0] ARP_PLEN_IPV4    = 8'd4;
    localparam logic [MAC_W-1:0] MAC_BROADCAST    = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [MAC_W-1:0] eth_dest_mac;
        logic [MAC_W-1:0] eth_src_mac;
        logic [FLD_W-1:0] eth_type;
        logic [FLD_W-1:0] arp_htype;
        logic [FLD_W-1:0] arp_ptype;
        logic [FLD_W-1:0] arp_oper;
        logic [MAC_W-1:0] arp_sha;
        logic [IP_W-1:0]  arp_spa;
        logic [MAC_W-1:0] arp_tha;
        logic [IP_W-1:0]  arp_tpa;
    } arp_frame_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } arp_state_e;

    typedef enum logic [1:0] {
        SEL_REPLY,
        SEL_REQ,
        SEL_GRAT
    } arp_sel_e;

    // Every outgoing frame is sourced from the station identity; only these fields vary.
    function automatic arp_frame_t arp_build(
        input logic [FLD_W-1:0] oper,
        input logic [MAC_W-1:0] dest,
        input logic [MAC_W-1:0] tha,
        input logic [IP_W-1:0]  tpa,
        input logic [MAC_W-1:0] mac,
        input logic [IP_W-1:0]  ip
    );
        arp_frame_t f;
        f.eth_dest_mac = dest;
        f.eth_src_mac  = mac;
        f.eth_type     = ETH_TYPE_ARP;
        f.arp_htype    = ARP_HTYPE_ETH;
        f.arp_ptype    = ARP_PTYPE_IPV4;
        f.arp_oper     = oper;
        f.arp_sha      = mac;
        f.arp_spa      = ip;
        f.arp_tha      = tha;
        f.arp_tpa      = tpa;
        return f;
    endfunction

endpackage

// File: rtl/arp_req_match.sv
// Combinational filter: flags an Ethernet/IPv4 ARP request aimed at the local IP.
module arp_req_match
    import arp_pkg::*;
#(
    parameter bit ACCEPT_PROBES = 1'b1
) (
    input  logic [FLD_W-1:0] i_htype,
    input  logic [FLD_W-1:0] i_ptype,
    input  logic [FLD_W-1:0] i_oper,
    input  logic [LEN_W-1:0] i_hlen,
    input  logic [LEN_W-1:0] i_plen,
    input  logic [IP_W-1:0]  i_spa,
    input  logic [IP_W-1:0]  i_tpa,
    input  logic [IP_W-1:0]  i_local_ip,
    output logic             o_match_c
);

    logic w_fmt_ok;
    logic w_is_req;
    logic w_for_us;
    logic w_spa_ok;

    assign w_fmt_ok = (i_htype == ARP_HTYPE_ETH) && (i_ptype == ARP_PTYPE_IPV4) &&
                      (i_hlen == ARP_HLEN_ETH) && (i_plen == ARP_PLEN_IPV4);
    assign w_is_req = (i_oper == ARP_OPER_REQUEST);
    assign w_for_us = (i_tpa == i_local_ip);
    // A zero sender IP marks an address-conflict probe.
    assign w_spa_ok = (i_spa != '0) || ACCEPT_PROBES;

    assign o_match_c = w_fmt_ok && w_is_req && w_for_us && w_spa_ok;

endmodule

// File: rtl/arp_responder.sv
// ARP engine: answers requests for the local IP and issues commanded (and optionally
// gratuitous, via ARP_RESPONDER_GRATUITOUS_EN) requests towards the ARP transmitter.
module arp_responder
    import arp_pkg::*;
#(
    parameter bit ACCEPT_PROBES = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_frame_valid,
    output logic             s_frame_ready,
    input  logic [MAC_W-1:0] s_eth_src_mac,
    input  logic [FLD_W-1:0] s_arp_htype,
    input  logic [FLD_W-1:0] s_arp_ptype,
    input  logic [FLD_W-1:0] s_arp_oper,
    input  logic [LEN_W-1:0] s_arp_hlen,
    input  logic [LEN_W-1:0] s_arp_plen,
    input  logic [MAC_W-1:0] s_arp_sha,
    input  logic [MAC_W-1:0] s_arp_tha,
    input  logic [IP_W-1:0]  s_arp_spa,
    input  logic [IP_W-1:0]  s_arp_tpa,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IP_W-1:0]  req_ip,
    input  logic             grat_trigger,
    input  logic [MAC_W-1:0] local_mac,
    input  logic [IP_W-1:0]  local_ip,
    output logic             m_frame_valid,
    input  logic             m_frame_ready,
    output logic [MAC_W-1:0] m_eth_dest_mac,
    output logic [MAC_W-1:0] m_eth_src_mac,
    output logic [FLD_W-1:0] m_eth_type,
    output logic [FLD_W-1:0] m_arp_htype,
    output logic [FLD_W-1:0] m_arp_ptype,
    output logic [FLD_W-1:0] m_arp_oper,
    output logic [MAC_W-1:0] m_arp_sha,
    output logic [MAC_W-1:0] m_arp_tha,
    output logic [IP_W-1:0]  m_arp_spa,
    output logic [IP_W-1:0]  m_arp_tpa,
    output logic             stat_drop,
    output logic             busy
);

    arp_state_e       r_state;
    arp_state_e       w_state_nxt;
    arp_sel_e         r_sel;
    arp_sel_e         w_sel_nxt;
    arp_frame_t       r_frame;
    arp_frame_t       w_frame_nxt;
    logic             w_load;
    logic             w_done;
    logic             r_valid;
    logic             r_drop;

    logic             r_rep_pend;
    logic [MAC_W-1:0] r_rep_mac;
    logic [MAC_W-1:0] r_rep_sha;
    logic [IP_W-1:0]  r_rep_spa;
    logic             r_req_pend;
    logic [IP_W-1:0]  r_req_ip;
    logic             w_grat_pend;

    logic             w_match;
    logic             w_frame_acc;
    logic             w_req_acc;
    logic             w_unused_tha;

    assign w_unused_tha = ^s_arp_tha;

    assign s_frame_ready = !r_rep_pend;
    assign req_ready     = !r_req_pend;
    assign w_frame_acc   = s_frame_valid && !r_rep_pend;
    assign w_req_acc     = req_valid && !r_req_pend;

    arp_req_match #(
        .ACCEPT_PROBES (ACCEPT_PROBES)
    ) u_match (
        .i_htype    (s_arp_htype),
        .i_ptype    (s_arp_ptype),
        .i_oper     (s_arp_oper),
        .i_hlen     (s_arp_hlen),
        .i_plen     (s_arp_plen),
        .i_spa      (s_arp_spa),
        .i_tpa      (s_arp_tpa),
        .i_local_ip (local_ip),
        .o_match_c  (w_match)
    );

    // Reply slot: snapshot of the request being answered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_pend <= 1'b0;
            r_rep_mac  <= '0;
            r_rep_sha  <= '0;
            r_rep_spa  <= '0;
        end else if (w_frame_acc && w_match) begin
            r_rep_pend <= 1'b1;
            r_rep_mac  <= s_eth_src_mac;
            r_rep_sha  <= s_arp_sha;
            r_rep_spa  <= s_arp_spa;
        end else if (w_done && (r_sel == SEL_REPLY)) begin
            r_rep_pend <= 1'b0;
        end
    end

    // Request slot: commanded address to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pend <= 1'b0;
            r_req_ip   <= '0;
        end else if (w_req_acc) begin
            r_req_pend <= 1'b1;
            r_req_ip   <= req_ip;
        end else if (w_done && (r_sel == SEL_REQ)) begin
            r_req_pend <= 1'b0;
        end
    end

`ifdef ARP_RESPONDER_GRATUITOUS_EN
    logic r_grat_pend;

    // Clear wins over a coincident trigger: a pulse while pending coalesces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grat_pend <= 1'b0;
        end else if (w_done && (r_sel == SEL_GRAT)) begin
            r_grat_pend <= 1'b0;
        end else if (grat_trigger) begin
            r_grat_pend <= 1'b1;
        end
    end

    assign w_grat_pend = r_grat_pend;
`else
    logic w_unused_grat;

    assign w_unused_grat = grat_trigger;
    assign w_grat_pend   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_REPLY;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Fixed priority reply > request > gratuitous; local identity sampled at load.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_frame_nxt = r_frame;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rep_pend) begin
                    w_load      = 1'b1;
                    w_sel_nxt   = SEL_REPLY;
                    w_frame_nxt = arp_build(ARP_OPER_REPLY, r_rep_mac, r_rep_sha, r_rep_spa,
                                            local_mac, local_ip);
                end else if (r_req_pend) begin
                    w_load      = 1'b1;
                    w_sel_nxt   = SEL_REQ;
                    w_frame_nxt = arp_build(ARP_OPER_REQUEST, MAC_BROADCAST, '0, r_req_ip,
                                            local_mac, local_ip);
                end else if (w_grat_pend) begin
                    w_load      = 1'b1;
                    w_sel_nxt   = SEL_GRAT;
                    w_frame_nxt = arp_build(ARP_OPER_REQUEST, MAC_BROADCAST, '0, local_ip,
                                            local_mac, local_ip);
                end
                if (w_load) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_frame_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_frame_acc && !w_match;
            if (w_load) begin
                r_frame <= w_frame_nxt;
                r_valid <= 1'b1;
            end else if (w_done) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_frame_valid  = r_valid;
    assign m_eth_dest_mac = r_frame.eth_dest_mac;
    assign m_eth_src_mac  = r_frame.eth_src_mac;
    assign m_eth_type     = r_frame.eth_type;
    assign m_arp_htype    = r_frame.arp_htype;
    assign m_arp_ptype    = r_frame.arp_ptype;
    assign m_arp_oper     = r_frame.arp_oper;
    assign m_arp_sha      = r_frame.arp_sha;
    assign m_arp_tha      = r_frame.arp_tha;
    assign m_arp_spa      = r_frame.arp_spa;
    assign m_arp_tpa      = r_frame.arp_tpa;
    assign stat_drop      = r_drop;
    assign busy           = r_rep_pend || r_req_pend || w_grat_pend || r_valid;

endmodule

// File: tb/tb_arp_responder.sv
// Bench for arp_responder: instance 1 answers probes, instance 0 filters them.
module tb_arp_responder;
    import arp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_frame_valid;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_arp_htype, s_arp_ptype, s_arp_oper;
    logic [7:0]  s_arp_hlen, s_arp_plen;
    logic [47:0] s_arp_sha, s_arp_tha;
    logic [31:0] s_arp_spa, s_arp_tpa;
    logic        req_valid;
    logic [31:0] req_ip;
    logic        grat_trigger;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        m_frame_ready;

    logic        o_sready [2];
    logic        o_rready [2];
    logic        o_valid  [2];
    arp_frame_t  o_fr     [2];
    logic        o_drop   [2];
    logic        o_busy   [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       w_sready, w_rready, w_valid, w_drop, w_busy;
        arp_frame_t w_fr;

        arp_responder #(.ACCEPT_PROBES(g == 1)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .s_frame_valid  (s_frame_valid),
            .s_frame_ready  (w_sready),
            .s_eth_src_mac  (s_eth_src_mac),
            .s_arp_htype    (s_arp_htype),
            .s_arp_ptype    (s_arp_ptype),
            .s_arp_oper     (s_arp_oper),
            .s_arp_hlen     (s_arp_hlen),
            .s_arp_plen     (s_arp_plen),
            .s_arp_sha      (s_arp_sha),
            .s_arp_tha      (s_arp_tha),
            .s_arp_spa      (s_arp_spa),
            .s_arp_tpa      (s_arp_tpa),
            .req_valid      (req_valid),
            .req_ready      (w_rready),
            .req_ip         (req_ip),
            .grat_trigger   (grat_trigger),
            .local_mac      (local_mac),
            .local_ip       (local_ip),
            .m_frame_valid  (w_valid),
            .m_frame_ready  (m_frame_ready),
            .m_eth_dest_mac (w_fr.eth_dest_mac),
            .m_eth_src_mac  (w_fr.eth_src_mac),
            .m_eth_type     (w_fr.eth_type),
            .m_arp_htype    (w_fr.arp_htype),
            .m_arp_ptype    (w_fr.arp_ptype),
            .m_arp_oper     (w_fr.arp_oper),
            .m_arp_sha      (w_fr.arp_sha),
            .m_arp_tha      (w_fr.arp_tha),
            .m_arp_spa      (w_fr.arp_spa),
            .m_arp_tpa      (w_fr.arp_tpa),
            .stat_drop      (w_drop),
            .busy           (w_busy)
        );

        assign o_sready[g] = w_sready;
        assign o_rready[g] = w_rready;
        assign o_valid[g]  = w_valid;
        assign o_fr[g]     = w_fr;
        assign o_drop[g]   = w_drop;
        assign o_busy[g]   = w_busy;
    end

    // ---------------- checking helpers ----------------
    function automatic void chk1(string nm, logic got, logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endfunction

    function automatic void chkf(string nm, arp_frame_t got, arp_frame_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    // Expected frame built directly from the field rules of the ARP responder.
    function automatic arp_frame_t mk(logic [47:0] dst, logic [15:0] op, logic [47:0] tha,
                                      logic [31:0] tpa);
        arp_frame_t f;
        f.eth_dest_mac = dst;
        f.eth_src_mac  = local_mac;
        f.eth_type     = 16'h0806;
        f.arp_htype    = 16'h0001;
        f.arp_ptype    = 16'h0800;
        f.arp_oper     = op;
        f.arp_sha      = local_mac;
        f.arp_spa      = local_ip;
        f.arp_tha      = tha;
        f.arp_tpa      = tpa;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_frame_valid = 1'b0;
        req_valid     = 1'b0;
        grat_trigger  = 1'b0;
    endtask

    task automatic drive_frame(logic [15:0] ht, logic [15:0] pt, logic [7:0] hl, logic [7:0] pl,
                               logic [15:0] op, logic [31:0] spa, logic [31:0] tpa,
                               logic [47:0] sha, logic [47:0] src);
        s_frame_valid = 1'b1;
        s_arp_htype   = ht;
        s_arp_ptype   = pt;
        s_arp_hlen    = hl;
        s_arp_plen    = pl;
        s_arp_oper    = op;
        s_arp_spa     = spa;
        s_arp_tpa     = tpa;
        s_arp_sha     = sha;
        s_arp_tha     = 48'h0;
        s_eth_src_mac = src;
    endtask

    task automatic chk_quiet(string tag);
        arp_frame_t zf;
        zf = '0;
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("%s_valid%0d", tag, k), o_valid[k], 1'b0);
            chkf($sformatf("%s_frame%0d", tag, k), o_fr[k], zf);
            chk1($sformatf("%s_drop%0d", tag, k), o_drop[k], 1'b0);
            chk1($sformatf("%s_busy%0d", tag, k), o_busy[k], 1'b0);
            chk1($sformatf("%s_sready%0d", tag, k), o_sready[k], 1'b1);
            chk1($sformatf("%s_rready%0d", tag, k), o_rready[k], 1'b1);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit          rep_p;
        logic [47:0] rep_mac, rep_sha;
        logic [31:0] rep_spa;
        bit          req_p;
        logic [31:0] rq_ip;
        bit          grat_p;
        bit          out_v;
        arp_frame_t  out;
        int          sel;
        bit          drop;
    } mdl_t;

    mdl_t md [2];

    function automatic void mdl_clear(int k);
        md[k].rep_p = 0; md[k].rep_mac = '0; md[k].rep_sha = '0; md[k].rep_spa = '0;
        md[k].req_p = 0; md[k].rq_ip = '0; md[k].grat_p = 0;
        md[k].out_v = 0; md[k].out = '0; md[k].sel = 0; md[k].drop = 0;
    endfunction

    function automatic bit ref_match(int k);
        return (s_arp_htype == 16'd1) && (s_arp_ptype == 16'h0800) && (s_arp_hlen == 8'd6) &&
               (s_arp_plen == 8'd4) && (s_arp_oper == 16'd1) && (s_arp_tpa == local_ip) &&
               ((s_arp_spa != 32'd0) || (k == 1));
    endfunction

    // Advance the model across one rising edge using the inputs currently driven.
    function automatic void mdl_step(int k);
        mdl_t n;
        bit   acc;
        n   = md[k];
        acc = s_frame_valid && !md[k].rep_p;
        n.drop = acc && !ref_match(k);
        if (acc && ref_match(k)) begin
            n.rep_p = 1; n.rep_mac = s_eth_src_mac; n.rep_sha = s_arp_sha; n.rep_spa = s_arp_spa;
        end
        if (req_valid && !md[k].req_p) begin
            n.req_p = 1; n.rq_ip = req_ip;
        end
`ifdef ARP_RESPONDER_GRATUITOUS_EN
        if (grat_trigger) n.grat_p = 1;
`endif
        if (md[k].out_v) begin
            if (m_frame_ready) begin
                n.out_v = 0;
                if (md[k].sel == 0) n.rep_p = 0;
                else if (md[k].sel == 1) n.req_p = 0;
                else n.grat_p = 0;
            end
        end else if (md[k].rep_p) begin
            n.out_v = 1; n.sel = 0; n.out = mk(md[k].rep_mac, 16'd2, md[k].rep_sha, md[k].rep_spa);
        end else if (md[k].req_p) begin
            n.out_v = 1; n.sel = 1; n.out = mk(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0, md[k].rq_ip);
        end else if (md[k].grat_p) begin
            n.out_v = 1; n.sel = 2; n.out = mk(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0, local_ip);
        end
        md[k] = n;
    endfunction

    // ---------------- match table ----------------
    typedef struct {
        logic [15:0] ht, pt, op;
        logic [7:0]  hl, pl;
        logic [31:0] spa, tpa;
        bit          rep_np;
        bit          rep_p;
    } vec_t;

    vec_t vt [9];

    localparam logic [31:0] IP_LOCAL = 32'h0A00_0005;
    localparam logic [31:0] IP_PEER  = 32'h0A00_0009;
    localparam logic [47:0] MAC_PEER = 48'h0200_0000_0009;

    initial begin
        arp_frame_t ef;
        int         seen;

        vt[0] = '{16'd1, 16'h0800, 16'd1, 8'd6, 8'd4,  IP_PEER, IP_LOCAL,       1'b1, 1'b1};
        vt[1] = '{16'd1, 16'h0800, 16'd1, 8'd6, 8'd4,  IP_PEER, 32'h0A00_0006,  1'b0, 1'b0};
        vt[2] = '{16'd1, 16'h0800, 16'd2, 8'd6, 8'd4,  IP_PEER, IP_LOCAL,       1'b0, 1'b0};
        vt[3] = '{16'd6, 16'h0800, 16'd1, 8'd6, 8'd4,  IP_PEER, IP_LOCAL,       1'b0, 1'b0};
        vt[4] = '{16'd1, 16'h86DD, 16'd1, 8'd6, 8'd4,  IP_PEER, IP_LOCAL,       1'b0, 1'b0};
        vt[5] = '{16'd1, 16'h0800, 16'd1, 8'd8, 8'd4,  IP_PEER, IP_LOCAL,       1'b0, 1'b0};
        vt[6] = '{16'd1, 16'h0800, 16'd1, 8'd6, 8'd16, IP_PEER, IP_LOCAL,       1'b0, 1'b0};
        vt[7] = '{16'd1, 16'h0800, 16'd1, 8'd6, 8'd4,  32'h0,   IP_LOCAL,       1'b0, 1'b1};
        vt[8] = '{16'd1, 16'h0800, 16'd3, 8'd6, 8'd4,  IP_PEER, IP_LOCAL,       1'b0, 1'b0};

        rst_n         = 1'b0;
        local_ip      = IP_LOCAL;
        local_mac     = 48'h02AA_BB00_0005;
        m_frame_ready = 1'b0;
        req_ip        = 32'h0;
        idle_in();
        drive_frame(16'd1, 16'h0800, 8'd6, 8'd4, 16'd1, IP_PEER, IP_LOCAL, MAC_PEER, MAC_PEER);
        s_frame_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("rst");
        rst_n = 1'b1;
        tick();
        chk_quiet("post_rst");

        // Match/drop table, zero-stall output
        for (int i = 0; i < 9; i++) begin
            logic [47:0] src, sha;
            bit          ex [2];
            src = 48'h0200_0000_0100 + 48'(i);
            sha = 48'h0200_0000_1000 + 48'(i);
            ex[0] = vt[i].rep_np;
            ex[1] = vt[i].rep_p;
            m_frame_ready = 1'b1;
            drive_frame(vt[i].ht, vt[i].pt, vt[i].hl, vt[i].pl, vt[i].op, vt[i].spa, vt[i].tpa,
                        sha, src);
            tick();
            s_frame_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("v%0d_drop%0d", i, k), o_drop[k], !ex[k]);
                chk1($sformatf("v%0d_sready%0d", i, k), o_sready[k], !ex[k]);
                chk1($sformatf("v%0d_early%0d", i, k), o_valid[k], 1'b0);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("v%0d_valid%0d", i, k), o_valid[k], ex[k]);
                chk1($sformatf("v%0d_dropend%0d", i, k), o_drop[k], 1'b0);
                if (ex[k])
                    chkf($sformatf("v%0d_frame%0d", i, k), o_fr[k], mk(src, 16'd2, sha, vt[i].spa));
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("v%0d_done%0d", i, k), o_valid[k], 1'b0);
                chk1($sformatf("v%0d_rel%0d", i, k), o_sready[k], 1'b1);
            end
            tick();
        end

        // Priority with a stalled sink: reply first and held, then the request
        m_frame_ready = 1'b0;
        drive_frame(16'd1, 16'h0800, 8'd6, 8'd4, 16'd1, IP_PEER, IP_LOCAL, MAC_PEER, MAC_PEER);
        req_valid = 1'b1;
        req_ip    = 32'h0A00_0001;
        tick();
        idle_in();
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("pri_sready%0d", k), o_sready[k], 1'b0);
            chk1($sformatf("pri_rready%0d", k), o_rready[k], 1'b0);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("pri_hold_v%0d_%0d", k, c), o_valid[k], 1'b1);
                chkf($sformatf("pri_hold_f%0d_%0d", k, c), o_fr[k],
                     mk(MAC_PEER, 16'd2, MAC_PEER, IP_PEER));
            end
            if (c < 5) tick();
        end
        m_frame_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("pri_gap%0d", k), o_valid[k], 1'b0);
            chk1($sformatf("pri_sready_back%0d", k), o_sready[k], 1'b1);
            chk1($sformatf("pri_rready_held%0d", k), o_rready[k], 1'b0);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("pri_req_v%0d", k), o_valid[k], 1'b1);
            chkf($sformatf("pri_req_f%0d", k), o_fr[k],
                 mk(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0, 32'h0A00_0001));
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("pri_end_v%0d", k), o_valid[k], 1'b0);
            chk1($sformatf("pri_end_rready%0d", k), o_rready[k], 1'b1);
            chk1($sformatf("pri_end_busy%0d", k), o_busy[k], 1'b0);
        end

        // Gratuitous pulses during SEND coalesce (ignored when the feature is absent)
        m_frame_ready = 1'b0;
        drive_frame(16'd1, 16'h0800, 8'd6, 8'd4, 16'd1, IP_PEER, IP_LOCAL, MAC_PEER, MAC_PEER);
        tick();
        idle_in();
        tick();
        repeat (3) begin
            grat_trigger = 1'b1;
            tick();
            grat_trigger = 1'b0;
            tick();
        end
        chk1("grat_reply_held", o_valid[1], 1'b1);
        m_frame_ready = 1'b1;
        tick();
        chk1("grat_gap", o_valid[1], 1'b0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_valid[1]) begin
                seen++;
                ef = mk(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0, IP_LOCAL);
                chkf("grat_frame", o_fr[1], ef);
            end
        end
`ifdef ARP_RESPONDER_GRATUITOUS_EN
        chk1("grat_count_one", 1'(seen == 1), 1'b1);
`else
        chk1("grat_count_zero", 1'(seen == 0), 1'b1);
`endif
        chk1("grat_busy", o_busy[1], 1'b0);

        // Reset while a frame is being offered
        m_frame_ready = 1'b0;
        drive_frame(16'd1, 16'h0800, 8'd6, 8'd4, 16'd1, IP_PEER, IP_LOCAL, MAC_PEER, MAC_PEER);
        req_valid = 1'b1;
        tick();
        idle_in();
        tick();
        chk1("mid_valid", o_valid[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("norep_v%0d_%0d", k, c), o_valid[k], 1'b0);
                chk1($sformatf("norep_sr%0d_%0d", k, c), o_sready[k], 1'b1);
                chk1($sformatf("norep_rr%0d_%0d", k, c), o_rready[k], 1'b1);
            end
        end

        // Randomized traffic against the reference model
        mdl_clear(0);
        mdl_clear(1);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("rnd_valid%0d_c%0d", k, c), o_valid[k], md[k].out_v);
                if (md[k].out_v)
                    chkf($sformatf("rnd_frame%0d_c%0d", k, c), o_fr[k], md[k].out);
                chk1($sformatf("rnd_sready%0d_c%0d", k, c), o_sready[k], !md[k].rep_p);
                chk1($sformatf("rnd_rready%0d_c%0d", k, c), o_rready[k], !md[k].req_p);
                chk1($sformatf("rnd_drop%0d_c%0d", k, c), o_drop[k], md[k].drop);
                chk1($sformatf("rnd_busy%0d_c%0d", k, c), o_busy[k],
                     md[k].rep_p || md[k].req_p || md[k].grat_p || md[k].out_v);
            end
            s_frame_valid = ($urandom_range(0, 9) < 4);
            s_arp_htype   = ($urandom_range(0, 15) == 0) ? 16'd6 : 16'd1;
            s_arp_ptype   = ($urandom_range(0, 15) == 0) ? 16'h86DD : 16'h0800;
            s_arp_hlen    = ($urandom_range(0, 15) == 0) ? 8'd8 : 8'd6;
            s_arp_plen    = ($urandom_range(0, 15) == 0) ? 8'd16 : 8'd4;
            s_arp_oper    = ($urandom_range(0, 3) == 0) ? 16'd2 : 16'd1;
            s_arp_tpa     = ($urandom_range(0, 2) == 0) ? 32'($urandom) : local_ip;
            s_arp_spa     = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            s_arp_sha     = 48'({$urandom, $urandom});
            s_arp_tha     = 48'({$urandom, $urandom});
            s_eth_src_mac = 48'({$urandom, $urandom});
            req_valid     = ($urandom_range(0, 4) == 0);
            req_ip        = 32'($urandom);
            grat_trigger  = ($urandom_range(0, 19) == 0);
            m_frame_ready = 1'($urandom_range(0, 1));
            mdl_step(0);
            mdl_step(1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
